seq_shift_add_mult: RTL and testbench

Parametrised, sequential shift-and-add multiplier. Successor to the team's combinational 4x4 multiplier, generalised to WIDTH-bit operands with a start/busy/done handshake. Processes one multiplier bit per clock, so one adder of WIDTH+1 bits replaces the full array. Sits in the arithmetic datapath wherever area matters more than single-cycle latency.

---
 rtl/seq_shift_add_mult.sv | 124 ++++++++++++
 tb/tb_seq_shift_add_mult.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier that retires one multiplier bit per clock.
// Optional two's-complement mode is compiled in with the SIGNED_MULT_EN macro.
module seq_shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
`ifdef SIGNED_MULT_EN
  input  logic                 sgn,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   s
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // done pulses for one cycle when s holds the new product; s is held otherwise.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             last_step;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] mplier_nxt;

  assign accept    = (state == IDLE) && start;
  assign last_step = (count == CNT_W'(WIDTH - 1));

`ifdef SIGNED_MULT_EN
  logic sgn_q;

  // Sign bit of each operand drops into the carry position only in signed mode.
  assign acc_ext   = {sgn_q & acc[WIDTH-1], acc};
  assign mcand_ext = {sgn_q & mcand[WIDTH-1], mcand};

  // The multiplier MSB has negative weight, so its partial product is subtracted.
  always_comb begin
    sum = acc_ext;
    if (mplier[0]) begin
      if (sgn_q && last_step) sum = acc_ext - mcand_ext;
      else                    sum = acc_ext + mcand_ext;
    end
  end
`else
  assign acc_ext   = {1'b0, acc};
  assign mcand_ext = {1'b0, mcand};

  always_comb begin
    sum = acc_ext;
    if (mplier[0]) sum = acc_ext + mcand_ext;
  end
`endif

  // {carry,acc,mplier} shifted right by one; the carry/sign bit becomes acc MSB.
  assign acc_nxt    = sum[WIDTH:1];
  assign mplier_nxt = {sum[0], mplier[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      done   <= 1'b0;
      s      <= '0;
`ifdef SIGNED_MULT_EN
      sgn_q  <= 1'b0;
`endif
    end else begin
      done <= (state == RUN) && last_step;
      if (accept) begin
        mcand  <= x;
        mplier <= y;
        acc    <= '0;
        count  <= '0;
`ifdef SIGNED_MULT_EN
        sgn_q  <= sgn;
`endif
      end else if (state == RUN) begin
        acc    <= acc_nxt;
        mplier <= mplier_nxt;
        count  <= count + 1'b1;
        if (last_step) s <= {acc_nxt, mplier_nxt};
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult: a 4-bit and an 8-bit instance checked against
// an integer-arithmetic reference model.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start4, busy4, done4;
  logic [3:0]  x4, y4;
  logic [7:0]  s4;
  logic        start8, busy8, done8;
  logic [7:0]  x8, y8;
  logic [15:0] s8;
`ifdef SIGNED_MULT_EN
  logic        sgn4, sgn8;
`endif

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  seq_shift_add_mult #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4),
`ifdef SIGNED_MULT_EN
    .sgn(sgn4),
`endif
    .busy(busy4), .done(done4), .s(s4)
  );

  seq_shift_add_mult #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8),
`ifdef SIGNED_MULT_EN
    .sgn(sgn8),
`endif
    .busy(busy8), .done(done8), .s(s8)
  );

  // Reference: plain integer product, operands reinterpreted as signed when asked.
  function automatic longint model(input int w, input logic [31:0] a,
                                   input logic [31:0] b, input logic sg);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sg && a[w-1]) sa = sa - (longint'(1) << w);
    if (sg && b[w-1]) sb = sb - (longint'(1) << w);
    return (sa * sb) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sg);
    int cyc;
    logic [7:0] prev, exp;
    exp  = 8'(model(4, 32'(a), 32'(b), sg));
    prev = s4;
    x4 = a; y4 = b; start4 = 1'b1;
`ifdef SIGNED_MULT_EN
    sgn4 = sg;
`endif
    @(negedge clk);
    start4 = 1'b0; x4 = 4'($urandom); y4 = 4'($urandom);
    cyc = 1;
    while (done4 !== 1'b1 && cyc < 40) begin
      check("busy4_run", 64'(busy4), 64'd1);
      check("s4_hold", 64'(s4), 64'(prev));
      @(negedge clk);
      cyc++;
    end
    check("lat4", 64'(cyc), 64'd5);
    check("s4", 64'(s4), 64'(exp));
    check("busy4_done", 64'(busy4), 64'd0);
    @(negedge clk);
    check("done4_pulse", 64'(done4), 64'd0);
    check("s4_kept", 64'(s4), 64'(exp));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int cyc;
    logic [15:0] prev, exp;
    exp  = 16'(model(8, 32'(a), 32'(b), sg));
    prev = s8;
    x8 = a; y8 = b; start8 = 1'b1;
`ifdef SIGNED_MULT_EN
    sgn8 = sg;
`endif
    @(negedge clk);
    start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom);
    cyc = 1;
    while (done8 !== 1'b1 && cyc < 60) begin
      check("busy8_run", 64'(busy8), 64'd1);
      check("s8_hold", 64'(s8), 64'(prev));
      @(negedge clk);
      cyc++;
    end
    check("lat8", 64'(cyc), 64'd9);
    check("s8", 64'(s8), 64'(exp));
    check("busy8_done", 64'(busy8), 64'd0);
    @(negedge clk);
    check("done8_pulse", 64'(done8), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, last_c;
    logic [15:0] got;
    logic prev_done;

    // clock/reset
    rst_n = 1'b0;
    start4 = 1'b0; x4 = '0; y4 = '0;
    start8 = 1'b0; x8 = '0; y8 = '0;
`ifdef SIGNED_MULT_EN
    sgn4 = 1'b0; sgn8 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_done4", 64'(done4), 64'd0);
    check("rst_s4", 64'(s4), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_s8", 64'(s8), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy4", 64'(busy4), 64'd0);

    // exhaustive 4x4 unsigned
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op4(4'(a), 4'(b), 1'b0);
    check("u4_15x15", 64'(s4), 64'h0E1);

    // 8-bit directed corners
    op8(8'hFF, 8'hFF, 1'b0);
    check("u8_ff_ff", 64'(s8), 64'hFE01);
    op8(8'h00, 8'hA5, 1'b0);
    check("u8_zero", 64'(s8), 64'h0);

    // 8-bit random unsigned
    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), 1'b0);

    // start while busy is ignored and operands are not re-captured
    x8 = 8'd3; y8 = 8'd5; start8 = 1'b1;
    ndone = 0; got = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin ndone++; got = s8; end
      if (c == 2) begin start8 = 1'b1; x8 = 8'd7; y8 = 8'd7; end
      else begin start8 = 1'b0; x8 = 8'($urandom); y8 = 8'($urandom); end
    end
    check("busy_ign_ndone", 64'(ndone), 64'd1);
    check("busy_ign_s", 64'(got), 64'd15);

    // reset in the middle of an operation
    x4 = 4'd6; y4 = 4'd7; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy4", 64'(busy4), 64'd0);
    check("midrst_done4", 64'(done4), 64'd0);
    check("midrst_s4", 64'(s4), 64'd0);
    check("midrst_s8", 64'(s8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) ndone++;
    end
    check("midrst_no_done", 64'(ndone), 64'd0);
    op4(4'd2, 4'd3, 1'b0);

    // start held high: back-to-back results every WIDTH+1 cycles
    for (int i = 0; i < 6; i++) exp_q.push_back(16'(model(4, 32'd5, 32'd3, 1'b0)));
    x4 = 4'd5; y4 = 4'd3; start4 = 1'b1;
    ndone = 0; last_c = 0; prev_done = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done4 === 1'b1) begin
        ndone++;
        check("hold_done_width", 64'(prev_done), 64'd0);
        check("hold_busy", 64'(busy4), 64'd0);
        if (last_c > 0) check("hold_period", 64'(c - last_c), 64'd5);
        else            check("hold_first", 64'(c), 64'd5);
        last_c = c;
        if (exp_q.size() > 0) check("hold_s4", 64'(s4), 64'(exp_q.pop_front()));
        else                  check("hold_extra_done", 64'(done4), 64'd0);
      end
      prev_done = done4;
    end
    start4 = 1'b0;
    check("hold_ndone", 64'(ndone), 64'd6);
    check("hold_q_empty", 64'(exp_q.size()), 64'd0);
    check("hold_s4_val", 64'(s4), 64'h0F);
    repeat (2) @(negedge clk);

`ifdef SIGNED_MULT_EN
    op4(4'h8, 4'h7, 1'b1);
    check("sgn_m8x7", 64'(s4), 64'hC8);
    op4(4'h8, 4'h8, 1'b1);
    check("sgn_m8xm8", 64'(s4), 64'h40);
    op4(4'h8, 4'h7, 1'b0);
    check("uns_8x7", 64'(s4), 64'h38);
    for (int i = 0; i < 30; i++) op8(8'($urandom), 8'($urandom), 1'($urandom));
    for (int i = 0; i < 20; i++) op4(4'($urandom), 4'($urandom), 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
